lcd_frame_gen: RTL
==================

Name: lcd_frame_gen

Overview:
Parametrised successor to our fixed 1280x40-word LCD frame sequencer. Generates the parallel LCD frame timing: update pulse, invert for DC balance, valid, and per-line blanking. Pulls pixel words from an upstream source through a ready/valid handshake instead of synthesising pattern data internally. Sits between the pixel source (frame buffer or pattern engine) and the panel pins, clocked from the PLL output.

Parameters:
DATA_WIDTH, 32, bits per pixel word on o_data / i_pixData
LINES, 1280, active lines per frame
WORDS_PER_LINE, 40, valid words per line
LINE_BLANK, 4, clocks per line with o_valid=0 after the words
BACK_PORCH, 24, clocks after the last line before the next frame
UPDATE_CLKS, 48, clocks o_update is high at frame start
INVERT_LEAD, 72, clocks o_invert is high at the start of a polarity-0 frame

Ports:
i_clock  in  1  PLL clock. All outputs change on its falling edge so the panel samples them on the rising edge.
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  run request
i_mode  in  1  0 = data frame alternates with a blank inverted frame; 1 = every frame carries data, odd frames send bitwise-inverted pixels
i_pixData  in  DATA_WIDTH  upstream pixel word
i_pixValid  in  1  upstream word available
o_pixReady  out  1  word consumed on this edge if i_pixValid is high
i_clearUnderflow  in  1  clears o_underflow
o_data  out  DATA_WIDTH  panel data
o_valid  out  1  panel data valid
o_update  out  1  panel update
o_invert  out  1  panel invert
o_frameStart  out  1  one-clock pulse at frame position 0
o_line  out  $clog2(LINES+1)  current line index
o_underflow  out  1  sticky: a slot needed data and i_pixValid was low
o_busy  out  1  state != IDLE

Behaviour:
- Derived constants: LINE_LEN = WORDS_PER_LINE + LINE_BLANK; DATA_END = LINES * LINE_LEN; FRAME_END = DATA_END + BACK_PORCH. Counters are sized with $clog2 of their maximum.
- Reset: state IDLE. All outputs 0, all counters 0, polarity p = 0.
- IDLE -> RUN when i_enable=1, entered at frame position 0.
- RUN: frame position pos runs 0..FRAME_END-1. Within the data region, linePos runs 0..LINE_LEN-1 and o_line counts up.
- Stop: if i_enable drops mid-frame, the current frame completes, including back porch, then the block enters IDLE. In mode 0, stop is also deferred until p = 0, so the DC-balance pair is completed.
- Frame-start outputs: o_frameStart = 1 at pos 0. o_update = 1 for pos < UPDATE_CLKS.
- Invert: o_invert = 1 when (p=0 and pos < INVERT_LEAD) or (p=1 and pos >= DATA_END).
- Data slot: any clock with pos < DATA_END and linePos < WORDS_PER_LINE.
- Data frame: mode 1, or mode 0 with p = 0.
- Data frame, data slot: o_pixReady = 1 and o_valid = 1.
  - If i_pixValid = 1, o_data = i_pixData, or ~i_pixData when mode 1 and p = 1.
  - Latency: the word is accepted and driven on the same falling edge. o_pixReady is decoded combinationally from the counters, one clock ahead of the registered outputs.
  - If i_pixValid = 0: o_data = 0, o_valid stays 1 so timing never stalls, and o_underflow is set.
- Blank inverted frame (mode 0, p = 1): o_valid = 0, o_data = 0, o_pixReady = 0 throughout.
- Line blank and back porch: o_valid = 0, o_data = 0, o_pixReady = 0.
- End of frame: at pos = FRAME_END-1, pos, linePos and o_line wrap to 0 and p toggles.
- i_mode is sampled only at pos 0; a change mid-frame takes effect at the next frame.
- o_underflow: set has priority over i_clearUnderflow on the same clock.
- Reset mid-frame: all outputs return to 0 immediately (asynchronous).

Decomposition:
- Package lcd_pkg:
  - mode enum (MODE_ALT_BLANK = 0, MODE_INV_DATA = 1)
  - state enum (IDLE, RUN)
  - function computing DATA_END / FRAME_END from the parameters
- One natural sub-module, lcd_frame_counter: pos, linePos, line and polarity counting with wrap strobes. The top level holds output decode and the handshake.

Test Plan:
All scenarios use LINES=4, WORDS_PER_LINE=3, LINE_BLANK=2, BACK_PORCH=3, UPDATE_CLKS=2, INVERT_LEAD=4, so DATA_END = 20 and FRAME_END = 23.
1. Reset then i_enable = 1, mode 0, source always valid with an incrementing count. Required: o_update high for pos 0-1, o_invert high for pos 0-3, o_valid high in pattern 3 on / 2 off ×4, data 0..11, o_frameStart every 23 clocks.
2. Second frame in mode 0. Required: o_valid = 0 and o_pixReady = 0 for the whole frame, o_invert = 1 exactly at pos 20-22.
3. Mode 1, data always 32'h0000_00FF. Required: frame 0 o_data = 0x000000FF; frame 1 o_data = 0xFFFFFF00 with o_valid high in the same slots.
4. i_pixValid held low for the 5th data slot. Required: o_data = 0 and o_valid = 1 that clock; o_underflow sticks at 1 until i_clearUnderflow pulses.
5. i_enable dropped at pos 10 of a p = 0 frame in mode 0. Required: that frame and the following blank frame complete, then o_busy = 0 with all outputs 0.
6. i_reset asserted at pos 7. Required: outputs go to 0 asynchronously; after release with i_enable = 1 the block restarts at pos 0 with p = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and derived-timing helpers for the LCD frame generator.
// Imported by the frame counter and by the top level.
package lcd_pkg;

    typedef enum logic {
        MODE_ALT_BLANK = 1'b0,
        MODE_INV_DATA  = 1'b1
    } lcdMode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lcdState_t;

    function automatic int calcDataEnd(input int lines, input int wordsPerLine,
                                       input int lineBlank);
        return lines * (wordsPerLine + lineBlank);
    endfunction

    function automatic int calcFrameEnd(input int lines, input int wordsPerLine,
                                        input int lineBlank, input int backPorch);
        return calcDataEnd(lines, wordsPerLine, lineBlank) + backPorch;
    endfunction

    // Bits needed to hold 0..maxVal, never less than one.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/lcd_frame_counter.sv
// Frame position, in-line position, line index and polarity counters.
// Advances on the falling edge while the generator runs; exposes region/wrap strobes.
module lcd_frame_counter
    import lcd_pkg::*;
#(
    parameter int LINES          = 1280,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINE_BLANK     = 4,
    parameter int BACK_PORCH     = 24,
    localparam int LINE_LEN      = WORDS_PER_LINE + LINE_BLANK,
    localparam int DATA_END      = calcDataEnd(LINES, WORDS_PER_LINE, LINE_BLANK),
    localparam int FRAME_END     = calcFrameEnd(LINES, WORDS_PER_LINE, LINE_BLANK, BACK_PORCH),
    localparam int POS_W         = cntWidth(FRAME_END - 1),
    localparam int LP_W          = cntWidth(LINE_LEN - 1),
    localparam int LINE_W        = cntWidth(LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    output logic [POS_W-1:0]  pos,
    output logic [LP_W-1:0]   linePos,
    output logic [LINE_W-1:0] line,
    output logic              polarity,
    output logic              inData,
    output logic              frameEnd
);

    logic lineEnd;

    assign inData   = int'(pos) < DATA_END;
    assign lineEnd  = int'(linePos) == LINE_LEN - 1;
    assign frameEnd = int'(pos) == FRAME_END - 1;

    // NOTE: all state here is sequential, so only non-blocking assignments are used;
    // the falling edge is the active edge so the panel sees stable values on its rising edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            pos      <= '0;
            linePos  <= '0;
            line     <= '0;
            polarity <= 1'b0;
        end else if (advance) begin
            if (frameEnd) begin
                pos      <= '0;
                linePos  <= '0;
                line     <= '0;
                polarity <= ~polarity;
            end else begin
                pos <= pos + POS_W'(1);
                // Line counting stops at LINES once the back porch begins.
                if (inData) begin
                    if (lineEnd) begin
                        linePos <= '0;
                        line    <= line + LINE_W'(1);
                    end else begin
                        linePos <= linePos + LP_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lcd_frame_gen.sv
// Parallel LCD frame sequencer: panel timing, DC-balance inversion and an
// upstream ready/valid pixel pull. Outputs launch on the falling edge of i_clock.
module lcd_frame_gen
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 1280,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINE_BLANK     = 4,
    parameter int BACK_PORCH     = 24,
    parameter int UPDATE_CLKS    = 48,
    parameter int INVERT_LEAD    = 72
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_mode,
    input  logic [DATA_WIDTH-1:0]        i_pixData,
    input  logic                         i_pixValid,
    output logic                         o_pixReady,
    input  logic                         i_clearUnderflow,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    output logic                         o_update,
    output logic                         o_invert,
    output logic                         o_frameStart,
    output logic [$clog2(LINES+1)-1:0]   o_line,
    output logic                         o_underflow,
    output logic                         o_busy
);

    localparam int LINE_LEN  = WORDS_PER_LINE + LINE_BLANK;
    localparam int DATA_END  = calcDataEnd(LINES, WORDS_PER_LINE, LINE_BLANK);
    localparam int FRAME_END = calcFrameEnd(LINES, WORDS_PER_LINE, LINE_BLANK, BACK_PORCH);
    localparam int POS_W     = cntWidth(FRAME_END - 1);
    localparam int LP_W      = cntWidth(LINE_LEN - 1);
    localparam int LINE_W    = $clog2(LINES + 1);

    lcdState_t             state, stateNext;
    lcdMode_t              frameMode, curMode;
    logic [POS_W-1:0]      pos;
    logic [LP_W-1:0]       linePos;
    logic [LINE_W-1:0]     line;
    logic                  polarity, inData, frameEnd;

    logic                  dataFrame, dataSlot, slotReady, stopReq, flipData;
    logic [DATA_WIDTH-1:0] dataNext;
    logic                  validNext, updateNext, invertNext, frameStartNext;
    logic [LINE_W-1:0]     lineNext;

    lcd_frame_counter #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINE_BLANK     (LINE_BLANK),
        .BACK_PORCH     (BACK_PORCH)
    ) u_counter (
        .clock    (i_clock),
        .reset    (i_reset),
        .advance  (state == RUN),
        .pos      (pos),
        .linePos  (linePos),
        .line     (line),
        .polarity (polarity),
        .inData   (inData),
        .frameEnd (frameEnd)
    );

    // The counters already point at the slot the next falling edge will emit,
    // so ready is decoded here and the word is captured on that same edge.
    assign o_pixReady = slotReady;
    assign o_busy     = (state == RUN);

    always_comb begin
        stateNext      = state;
        curMode        = (pos == '0) ? lcdMode_t'(i_mode) : frameMode;
        dataFrame      = (curMode == MODE_INV_DATA) || !polarity;
        dataSlot       = inData && (int'(linePos) < WORDS_PER_LINE);
        slotReady      = (state == RUN) && dataFrame && dataSlot;
        flipData       = (curMode == MODE_INV_DATA) && polarity;
        // Mode 0 only stops after the blank inverted frame, keeping the DC-balance pair whole.
        stopReq        = frameEnd && !i_enable && ((curMode == MODE_INV_DATA) || polarity);
        dataNext       = '0;
        validNext      = 1'b0;
        updateNext     = 1'b0;
        invertNext     = 1'b0;
        frameStartNext = 1'b0;
        lineNext       = '0;

        case (state)
            IDLE: begin
                if (i_enable) stateNext = RUN;
            end
            RUN: begin
                if (stopReq) stateNext = IDLE;
                validNext      = slotReady;
                if (slotReady && i_pixValid)
                    dataNext = flipData ? ~i_pixData : i_pixData;
                updateNext     = int'(pos) < UPDATE_CLKS;
                invertNext     = (!polarity && (int'(pos) < INVERT_LEAD)) ||
                                 ( polarity && (int'(pos) >= DATA_END));
                frameStartNext = (pos == '0);
                lineNext       = line;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            frameMode    <= MODE_ALT_BLANK;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_update     <= 1'b0;
            o_invert     <= 1'b0;
            o_frameStart <= 1'b0;
            o_line       <= '0;
            o_underflow  <= 1'b0;
        end else begin
            state        <= stateNext;
            if (state == RUN && pos == '0)
                frameMode <= curMode;
            o_data       <= dataNext;
            o_valid      <= validNext;
            o_update     <= updateNext;
            o_invert     <= invertNext;
            o_frameStart <= frameStartNext;
            o_line       <= lineNext;
            // A missing word wins over a same-cycle clear so no underflow is lost.
            if (slotReady && !i_pixValid)
                o_underflow <= 1'b1;
            else if (i_clearUnderflow)
                o_underflow <= 1'b0;
        end
    end

endmodule
